param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file_pkg.sv | 11 +
 rtl/param_reg_file_reg_scoreboard.sv | 57 +++++
 rtl/param_reg_file.sv | 100 ++++++++++
 tb/tb_param_reg_file.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared register-file constants and the CPU datapath word type.
package param_reg_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RPORTS = 3;

  typedef logic [DATA_W_DEF-1:0] data_word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/param_reg_file_reg_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by reservation,
// cleared by a write, looked up by each read port.
module reg_scoreboard
  import param_reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit BYPASS   = 1'b0,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rsv_en_i,
  input  logic [ADDR_W-1:0]     rsv_addr_i,
  input  logic                  clr_a_en_i,
  input  logic [ADDR_W-1:0]     clr_a_addr_i,
  input  logic                  clr_b_en_i,
  input  logic [ADDR_W-1:0]     clr_b_addr_i,
  input  logic [ADDR_W-1:0]     look_addr_i [NUM_RPORTS],
  output logic [NUM_RPORTS-1:0] busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             rsv_ok;

  assign rsv_ok = rsv_en_i && !(ZERO_REG && rsv_addr_i == '0);

  // Reservation is applied after the clear so a new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_a_en_i) pending_d[clr_a_addr_i] = 1'b0;
    if (clr_b_en_i) pending_d[clr_b_addr_i] = 1'b0;
    if (rsv_ok)     pending_d[rsv_addr_i]   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  always_comb begin
    busy_o = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      busy_o[p] = pending_q[look_addr_i[p]];
      if (BYPASS &&
          ((clr_a_en_i && clr_a_addr_i == look_addr_i[p]) ||
           (clr_b_en_i && clr_b_addr_i == look_addr_i[p])) &&
          !(rsv_ok && rsv_addr_i == look_addr_i[p]))
        busy_o[p] = 1'b0;
      if (ZERO_REG && look_addr_i[p] == '0) busy_o[p] = 1'b0;
      if (!rst_ni) busy_o[p] = 1'b0;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Two-write / three-read register file with optional write-to-read bypass,
// optional hard-wired zero register and a pending-bit scoreboard.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit BYPASS   = 1'b0,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Rd_Addr,
  input  logic [ADDR_W-1:0] Rs_Addr,
  input  logic [ADDR_W-1:0] Rm_Addr,
  input  logic              Rd_Wen,
  input  logic              Rs_Wen,
  input  logic [DATA_W-1:0] Rd_Data,
  input  logic [DATA_W-1:0] Rs_Data,
  output logic [DATA_W-1:0] Rd_Out,
  output logic [DATA_W-1:0] Rs_Out,
  output logic [DATA_W-1:0] Rm_Out,
  input  logic              Rsv_En,
  input  logic [ADDR_W-1:0] Rsv_Addr,
  output logic              Busy_Rd,
  output logic              Busy_Rs,
  output logic              Busy_Rm
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]     regs_q [DEPTH];
  logic [DATA_W-1:0]     regs_d [DEPTH];
  logic [ADDR_W-1:0]     raddr  [NUM_RPORTS];
  logic [DATA_W-1:0]     rdata  [NUM_RPORTS];
  logic [NUM_RPORTS-1:0] busy;
  logic                  wd_en;
  logic                  ws_en;

  // Writes to r0 are dropped entirely when it is hard-wired to zero.
  assign wd_en = Rd_Wen && !(ZERO_REG && Rd_Addr == '0);
  assign ws_en = Rs_Wen && !(ZERO_REG && Rs_Addr == '0);

  // Port S is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (wd_en) regs_d[Rd_Addr] = Rd_Data;
    if (ws_en) regs_d[Rs_Addr] = Rs_Data;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign raddr[0] = Rd_Addr;
  assign raddr[1] = Rs_Addr;
  assign raddr[2] = Rm_Addr;

  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rdata[p] = regs_q[raddr[p]];
      if (BYPASS) begin
        if (ws_en && Rs_Addr == raddr[p])      rdata[p] = Rs_Data;
        else if (wd_en && Rd_Addr == raddr[p]) rdata[p] = Rd_Data;
      end
      if (ZERO_REG && raddr[p] == '0) rdata[p] = '0;
      if (!Reset_n)                   rdata[p] = '0;
    end
  end

  assign Rd_Out = rdata[0];
  assign Rs_Out = rdata[1];
  assign Rm_Out = rdata[2];

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i       (Clock),
    .rst_ni      (Reset_n),
    .rsv_en_i    (Rsv_En),
    .rsv_addr_i  (Rsv_Addr),
    .clr_a_en_i  (wd_en),
    .clr_a_addr_i(Rd_Addr),
    .clr_b_en_i  (ws_en),
    .clr_b_addr_i(Rs_Addr),
    .look_addr_i (raddr),
    .busy_o      (busy)
  );

  assign Busy_Rd = busy[0];
  assign Busy_Rs = busy[1];
  assign Busy_Rm = busy[2];

endmodule

// File: tb/tb_param_reg_file.sv
// Bench: two configurations (plain, bypass+zero-reg) share one stimulus stream
// and are compared each cycle against an array-based model of the register file.
module tb_param_reg_file;
  import param_reg_file_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [3:0] Rd_Addr, Rs_Addr, Rm_Addr, Rsv_Addr;
  logic       Rd_Wen, Rs_Wen, Rsv_En;
  data_word_t Rd_Data, Rs_Data;

  data_word_t a_rd, a_rs, a_rm, b_rd, b_rs, b_rm;
  logic       a_brd, a_brs, a_brm, b_brd, b_brs, b_brm;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Model state: index 0 = plain config, index 1 = bypass + zero-reg config.
  logic [15:0] m_mem  [2][16];
  logic        m_pend [2][16];

  always #5 Clock = ~Clock;

  param_reg_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_a (
    .Clock(Clock), .Reset_n(Reset_n),
    .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
    .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen), .Rd_Data(Rd_Data), .Rs_Data(Rs_Data),
    .Rd_Out(a_rd), .Rs_Out(a_rs), .Rm_Out(a_rm),
    .Rsv_En(Rsv_En), .Rsv_Addr(Rsv_Addr),
    .Busy_Rd(a_brd), .Busy_Rs(a_brs), .Busy_Rm(a_brm)
  );

  param_reg_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_b (
    .Clock(Clock), .Reset_n(Reset_n),
    .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
    .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen), .Rd_Data(Rd_Data), .Rs_Data(Rs_Data),
    .Rd_Out(b_rd), .Rs_Out(b_rs), .Rm_Out(b_rm),
    .Rsv_En(Rsv_En), .Rsv_Addr(Rsv_Addr),
    .Busy_Rd(b_brd), .Busy_Rs(b_brs), .Busy_Rm(b_brm)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_out(input int c, input logic [3:0] a);
    if (!Reset_n) return 16'h0;
    if (c == 1 && a == 4'd0) return 16'h0;
    if (c == 1) begin
      if (Rs_Wen && Rs_Addr == a) return Rs_Data;
      if (Rd_Wen && Rd_Addr == a) return Rd_Data;
    end
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [3:0] a);
    bit written, reserved;
    if (!Reset_n) return 1'b0;
    if (c == 1 && a == 4'd0) return 1'b0;
    written  = (Rd_Wen && Rd_Addr == a) || (Rs_Wen && Rs_Addr == a);
    reserved = Rsv_En && Rsv_Addr == a;
    if (c == 1 && written && !reserved) return 1'b0;
    return m_pend[c][a];
  endfunction

  // Reference model: write then reserve, later assignments win.
  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 16; i++) begin
          m_mem[c][i]  <= 16'h0;
          m_pend[c][i] <= 1'b0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (Rd_Wen && !(c == 1 && Rd_Addr == 4'd0)) begin
          m_mem[c][Rd_Addr]  <= Rd_Data;
          m_pend[c][Rd_Addr] <= 1'b0;
        end
        if (Rs_Wen && !(c == 1 && Rs_Addr == 4'd0)) begin
          m_mem[c][Rs_Addr]  <= Rs_Data;
          m_pend[c][Rs_Addr] <= 1'b0;
        end
        if (Rsv_En && !(c == 1 && Rsv_Addr == 4'd0))
          m_pend[c][Rsv_Addr] <= 1'b1;
      end
    end
  end

  always @(negedge Clock) begin
    if (cmp_on) begin
      chk("a_rd_out",  a_rd,         exp_out(0, Rd_Addr));
      chk("a_rs_out",  a_rs,         exp_out(0, Rs_Addr));
      chk("a_rm_out",  a_rm,         exp_out(0, Rm_Addr));
      chk("a_busy_rd", 16'(a_brd),   16'(exp_busy(0, Rd_Addr)));
      chk("a_busy_rs", 16'(a_brs),   16'(exp_busy(0, Rs_Addr)));
      chk("a_busy_rm", 16'(a_brm),   16'(exp_busy(0, Rm_Addr)));
      chk("b_rd_out",  b_rd,         exp_out(1, Rd_Addr));
      chk("b_rs_out",  b_rs,         exp_out(1, Rs_Addr));
      chk("b_rm_out",  b_rm,         exp_out(1, Rm_Addr));
      chk("b_busy_rd", 16'(b_brd),   16'(exp_busy(1, Rd_Addr)));
      chk("b_busy_rs", 16'(b_brs),   16'(exp_busy(1, Rs_Addr)));
      chk("b_busy_rm", 16'(b_brm),   16'(exp_busy(1, Rm_Addr)));
    end
  end

  task automatic idle();
    Rd_Wen = 1'b0; Rs_Wen = 1'b0; Rsv_En = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge Clock); #1;
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    // Reset with writes and a reservation pending; all must be discarded.
    Reset_n = 1'b0;
    Rd_Addr = 4'd2; Rs_Addr = 4'd2; Rm_Addr = 4'd2; Rsv_Addr = 4'd2;
    Rd_Wen = 1'b1; Rs_Wen = 1'b1; Rsv_En = 1'b1;
    Rd_Data = 16'hFFFF; Rs_Data = 16'hEEEE;
    repeat (3) next_cycle();
    Reset_n = 1'b1;
    idle();
    cmp_on = 1'b1;

    for (int a = 0; a < 16; a++) begin
      Rd_Addr = 4'(a); Rs_Addr = 4'(a); Rm_Addr = 4'(a);
      #1;
      chk("rst_a_rd", a_rd, 16'h0000);
      chk("rst_a_rs", a_rs, 16'h0000);
      chk("rst_a_rm", a_rm, 16'h0000);
      chk("rst_a_busy", 16'({a_brd, a_brs, a_brm}), 16'h0);
      chk("rst_b_busy", 16'({b_brd, b_brs, b_brm}), 16'h0);
    end
    next_cycle();

    // Dual write to r5: port S wins.
    Rd_Addr = 4'd5; Rd_Data = 16'h1234; Rd_Wen = 1'b1;
    Rs_Addr = 4'd5; Rs_Data = 16'hABCD; Rs_Wen = 1'b1;
    Rm_Addr = 4'd4;
    next_cycle();
    idle(); Rm_Addr = 4'd5; #1;
    chk("r5_s_wins_a", a_rm, 16'hABCD);
    chk("r5_s_wins_b", b_rm, 16'hABCD);

    // Bypass versus registered visibility on r3.
    Rd_Addr = 4'd3; Rd_Data = 16'h00FF; Rd_Wen = 1'b1; Rs_Addr = 4'd6; Rm_Addr = 4'd3; #1;
    chk("r3_bypass_b", b_rm, 16'h00FF);
    chk("r3_old_a",    a_rm, 16'h0000);
    next_cycle();
    idle(); #1;
    chk("r3_new_a", a_rm, 16'h00FF);

    // Scoreboard on r7.
    Rsv_En = 1'b1; Rsv_Addr = 4'd7; Rm_Addr = 4'd7; #1;
    chk("r7_not_yet", 16'(a_brm), 16'h0);
    next_cycle();
    idle(); #1;
    chk("r7_busy_a", 16'(a_brm), 16'h1);
    chk("r7_busy_b", 16'(b_brm), 16'h1);
    Rd_Addr = 4'd7; Rd_Data = 16'h0707; Rd_Wen = 1'b1; #1;
    chk("r7_byp_busy_b", 16'(b_brm), 16'h0);
    chk("r7_wr_busy_a",  16'(a_brm), 16'h1);
    next_cycle();
    idle(); #1;
    chk("r7_cleared_a", 16'(a_brm), 16'h0);
    Rsv_En = 1'b1; Rsv_Addr = 4'd7; Rs_Addr = 4'd7; Rs_Data = 16'h7A7A; Rs_Wen = 1'b1;
    next_cycle();
    idle(); #1;
    chk("r7_rsv_wins_a", 16'(a_brm), 16'h1);
    chk("r7_rsv_wins_b", 16'(b_brm), 16'h1);
    chk("r7_data_a",     a_rm,       16'h7A7A);

    // Zero register.
    Rd_Addr = 4'd0; Rd_Data = 16'h5555; Rd_Wen = 1'b1;
    Rsv_En = 1'b1; Rsv_Addr = 4'd0; Rm_Addr = 4'd0; Rs_Addr = 4'd1; #1;
    chk("r0_no_bypass_b", b_rm, 16'h0000);
    next_cycle();
    idle(); #1;
    chk("r0_zero_b",  b_rm,       16'h0000);
    chk("r0_busy_b",  16'(b_brm), 16'h0);
    chk("r0_data_a",  a_rm,       16'h5555);
    chk("r0_busy_a",  16'(a_brm), 16'h1);

    // Asynchronous reset mid-cycle with r9 pending.
    Rd_Addr = 4'd9; Rd_Data = 16'h7777; Rd_Wen = 1'b1; Rsv_En = 1'b1; Rsv_Addr = 4'd9;
    next_cycle();
    idle(); Rm_Addr = 4'd9; Rd_Addr = 4'd2; #1;
    chk("r9_data_a", a_rm,       16'h7777);
    chk("r9_busy_a", 16'(a_brm), 16'h1);
    #1;
    Reset_n = 1'b0;
    Rd_Addr = 4'd9; Rd_Data = 16'h1111; Rd_Wen = 1'b1; Rsv_En = 1'b1; Rsv_Addr = 4'd8;
    #1;
    chk("rst_async_a_rm",   a_rm,       16'h0000);
    chk("rst_async_a_busy", 16'(a_brm), 16'h0);
    chk("rst_async_b_rm",   b_rm,       16'h0000);
    repeat (2) next_cycle();
    Reset_n = 1'b1;
    idle(); #1;
    chk("r9_cleared_a",   a_rm,       16'h0000);
    chk("r9_unpending_a", 16'(a_brm), 16'h0);
    Rm_Addr = 4'd8; #1;
    chk("r8_rsv_dropped", 16'(a_brm), 16'h0);

    // Randomized traffic with occasional reset cycles.
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      Reset_n  = ($urandom_range(0, 49) != 0);
      Rd_Addr  = rnd_addr();
      Rs_Addr  = rnd_addr();
      Rm_Addr  = rnd_addr();
      Rsv_Addr = rnd_addr();
      Rd_Wen   = 1'($urandom_range(0, 1));
      Rs_Wen   = 1'($urandom_range(0, 1));
      Rsv_En   = ($urandom_range(0, 2) == 0);
      Rd_Data  = 16'($urandom);
      Rs_Data  = 16'($urandom);
    end
    next_cycle();
    Reset_n = 1'b1;
    idle();
    next_cycle();
    cmp_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
